stdp_sipo_frame_deser: RTL and testbench
========================================

Name: stdp_sipo_frame_deser

Overview:
- Multi-channel, parametrised serial-to-parallel deserialiser for spike/weight bit streams in the STDP learning engine.
- Each channel shifts one bit per global time-step, on the cycle where the shared global_counter equals SHIFT_TICK.
- After WIDTH shifts, all channels' words are captured as one frame in an output holding register. The frame is presented with a valid/ready handshake, with overrun detection.
- Sits between the serial spike/trace sources and the parallel weight-update datapath.

Parameters:
- NCH, 4, number of independent serial channels.
- WIDTH, 16, bits per channel word (frame length in shifts); must be >= 2.
- CNT_W, 5, width of global_counter.
- SHIFT_TICK, 15, global_counter value on which a shift occurs.
- SHIFT_DIR, 0, 0 = right shift (serial bit enters the MSB, so the first bit received ends in bit 0); 1 = left shift (serial bit enters the LSB, so the first bit received ends in bit WIDTH-1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- global_counter  in  CNT_W  shared time-step counter
- en  in  1  shift enable; shifts are qualified by en
- clear  in  1  synchronous soft clear
- serial_in  in  NCH  one serial bit per channel; bit c belongs to channel c
- out_ready  in  1  consumer accepts the frame
- frame_data  out  NCH*WIDTH  captured frame; channel c occupies bits [c*WIDTH +: WIDTH]
- frame_valid  out  1  frame_data holds an unconsumed frame
- overrun  out  1  sticky flag: a completed frame was dropped
- bit_count  out  $clog2(WIDTH+1)  number of shifts accumulated in the current partial frame (0..WIDTH-1)

Behaviour:
- Priority: rst > clear > normal operation. All state is updated on the rising edge of clk.
- Reset values: all shift registers 0, bit_count 0, frame_data 0, frame_valid 0, overrun 0.
- clear: same effect as rst on all state, including the output register and the flags.
- shift_evt = en && (global_counter == SHIFT_TICK). This holds for a single cycle per counter wrap, so there is one shift per 2^CNT_W cycles when the counter is free-running.
- On shift_evt:
  - Every channel shifts in its serial_in bit per SHIFT_DIR.
  - bit_count increments.
- Frame completion: a shift_evt while bit_count == WIDTH-1.
  - The full words, including the current bit, go to the output side.
  - The shift registers and bit_count are reset to 0 on the same edge.
- Completion with frame_valid == 0, or with frame_valid == 1 && out_ready == 1 on that cycle:
  - frame_data is loaded with the new frame.
  - frame_valid = 1 after the same edge (zero extra latency).
- Completion with frame_valid == 1 && out_ready == 0:
  - The new frame is dropped; frame_data and frame_valid are unchanged.
  - overrun is set and stays set until rst or clear.
- Handshake:
  - Transfer = frame_valid && out_ready.
  - Without a simultaneous completion, a transfer clears frame_valid next edge; frame_data holds its last value.
  - frame_data must not change while frame_valid == 1 except through a transfer plus reload on the same edge.
- No shift_evt: shift registers and bit_count hold. out_ready with frame_valid == 0 has no effect.
- en low: no shifts occur. The handshake and output side keep operating.
- rst/clear mid-frame: the partial frame is discarded. The next frame starts at bit_count 0.
- SHIFT_TICK >= 2^CNT_W is illegal; flag it with an elaboration-time assertion.

Test Plan:
- Right-shift frame, NCH=2, WIDTH=4, SHIFT_DIR=0, counter free-running 0..31:
  - Stimulus: ch0 bits 1,0,1,1 and ch1 bits 0,0,0,1 on four tick-15 cycles.
  - Required: frame_data = 0x8D and frame_valid = 1 on the edge of the 4th tick; bit_count returns to 0.
- Left-shift mode, same stimulus with SHIFT_DIR=1:
  - Required: ch0 = 0xB, ch1 = 0x1, so frame_data = 0x1B.
- Gating:
  - global_counter held at 14, then 16, for 100 cycles: bit_count stays 0.
  - en = 0 across a tick-15 cycle: no shift.
- Overrun with out_ready held 0:
  - First frame 0x8D completes, then a second frame 0x00 completes.
  - Required: frame_data stays 0x8D, frame_valid stays 1, overrun = 1.
  - out_ready pulsed for 1 cycle: frame_valid goes to 0 and overrun stays 1.
- Back-to-back reload:
  - out_ready = 1 on the exact completion cycle of a second frame 0x5A.
  - Required: frame_data = 0x5A, frame_valid stays 1, overrun stays 0.
- Clear mid-frame:
  - clear asserted after 2 of 4 shifts.
  - Required: bit_count = 0, frame_valid = 0, overrun = 0; the next full 4 shifts produce the correct frame.

Source files
------------

// File: rtl/stdp_sipo_frame_deser_if.sv
// Serial-side and frame-side signal bundle for stdp_sipo_frame_deser.
// The slave modport is the deserialiser's view; the master modport is the source/consumer view.
interface stdp_sipo_frame_deser_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  localparam int BC_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]     global_counter;
  logic                 en;
  logic                 clear;
  logic [NCH-1:0]       serial_in;
  logic                 out_ready;
  logic [NCH*WIDTH-1:0] frame_data;
  logic                 frame_valid;
  logic                 overrun;
  logic [BC_W-1:0]      bit_count;

  modport master (
    output global_counter, en, clear, serial_in, out_ready,
    input  frame_data, frame_valid, overrun, bit_count
  );

  modport slave (
    input  global_counter, en, clear, serial_in, out_ready,
    output frame_data, frame_valid, overrun, bit_count
  );
endinterface

// File: rtl/stdp_sipo_frame_deser.sv
// Multi-channel SIPO: one shift per SHIFT_TICK; a full frame lands in frame_data on the completing edge.
// Valid/ready output; a completion while a frame is still pending is dropped and sets sticky overrun.
module stdp_sipo_frame_deser #(
  parameter int NCH        = 4,
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 5,
  parameter int SHIFT_TICK = 15,
  parameter int SHIFT_DIR  = 0
) (
  input logic                   clk,
  input logic                   rst,
  stdp_sipo_frame_deser_if.slave io
);
  localparam int BC_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] TICK = CNT_W'(SHIFT_TICK);
  localparam logic [BC_W-1:0]  LAST = BC_W'(WIDTH - 1);

  if (SHIFT_TICK < 0 || (SHIFT_TICK >> CNT_W) != 0) begin : g_bad_tick
    $error("SHIFT_TICK does not fit in a CNT_W-bit global_counter");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end

  logic [NCH-1:0][WIDTH-1:0] sh_q;
  logic [NCH-1:0][WIDTH-1:0] sh_nxt;
  logic [BC_W-1:0]           bc_q;
  logic [NCH*WIDTH-1:0]      frame_q;
  logic                      valid_q;
  logic                      over_q;

  logic shift_evt;
  logic complete;
  logic xfer;
  logic load;
  logic drop;

  assign shift_evt = io.en && (io.global_counter == TICK);
  assign complete  = shift_evt && (bc_q == LAST);
  assign xfer      = valid_q && io.out_ready;
  assign load      = complete && (!valid_q || io.out_ready);
  assign drop      = complete && valid_q && !io.out_ready;

  // Words including the bit arriving this cycle; also the frame captured on completion.
  always_comb begin
    sh_nxt = sh_q;
    for (int c = 0; c < NCH; c++) begin
      if (SHIFT_DIR == 0) begin
        sh_nxt[c] = {io.serial_in[c], sh_q[c][WIDTH-1:1]};
      end else begin
        sh_nxt[c] = {sh_q[c][WIDTH-2:0], io.serial_in[c]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || io.clear) begin
      sh_q    <= '0;
      bc_q    <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      if (shift_evt) begin
        if (complete) begin
          sh_q <= '0;
          bc_q <= '0;
        end else begin
          sh_q <= sh_nxt;
          bc_q <= bc_q + BC_W'(1);
        end
      end
      if (load) begin
        frame_q <= sh_nxt;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      if (drop) begin
        over_q <= 1'b1;
      end
    end
  end

  assign io.frame_data  = frame_q;
  assign io.frame_valid = valid_q;
  assign io.overrun     = over_q;
  assign io.bit_count   = bc_q;
endmodule

// File: tb/tb_stdp_sipo_frame_deser.sv
// Drives right- and left-shift instances with identical stimulus; a bit-history model predicts each edge.
module tb_stdp_sipo_frame_deser;
  localparam int NCH   = 2;
  localparam int WIDTH = 4;
  localparam int CNT_W = 5;
  localparam int TICK  = 15;
  localparam int BC_W  = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stdp_sipo_frame_deser_if #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W)) if_r ();
  stdp_sipo_frame_deser_if #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W)) if_l ();

  stdp_sipo_frame_deser #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W), .SHIFT_TICK(TICK), .SHIFT_DIR(0))
    dut_r (.clk(clk), .rst(rst), .io(if_r));
  stdp_sipo_frame_deser #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W), .SHIFT_TICK(TICK), .SHIFT_DIR(1))
    dut_l (.clk(clk), .rst(rst), .io(if_l));

  typedef struct {
    logic [BC_W-1:0]      bc;
    logic                 vld;
    logic                 ovr;
    logic [NCH*WIDTH-1:0] fr;
    logic [NCH*WIDTH-1:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: raw bit history per channel, frames assembled from arrival order.
  bit                   m_hist [NCH][WIDTH];
  int                   m_n;
  logic                 m_vld;
  logic                 m_ovr;
  logic [NCH*WIDTH-1:0] m_fr;
  logic [NCH*WIDTH-1:0] m_fl;

  bit rdy_base = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit clr, input int gc, input bit en_v,
                       input bit [NCH-1:0] sin, input bit rdy);
    exp_t e;
    bit complete;
    logic [NCH*WIDTH-1:0] fr, fl;
    complete = 1'b0;
    fr = '0;
    fl = '0;
    if (r || clr) begin
      m_n = 0; m_vld = 1'b0; m_ovr = 1'b0; m_fr = '0; m_fl = '0;
    end else begin
      if (en_v && gc == TICK) begin
        for (int c = 0; c < NCH; c++) m_hist[c][m_n] = sin[c];
        m_n++;
        if (m_n == WIDTH) begin
          complete = 1'b1;
          for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < WIDTH; i++) begin
              fr[c*WIDTH + i]             = m_hist[c][i];
              fl[c*WIDTH + WIDTH - 1 - i] = m_hist[c][i];
            end
          end
          m_n = 0;
        end
      end
      if (complete && (!m_vld || rdy)) begin
        m_fr = fr; m_fl = fl; m_vld = 1'b1;
      end else if (complete) begin
        m_ovr = 1'b1;
      end else if (m_vld && rdy) begin
        m_vld = 1'b0;
      end
    end
    e.bc = BC_W'(m_n); e.vld = m_vld; e.ovr = m_ovr; e.fr = m_fr; e.fl = m_fl;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit clr, input int gc, input bit en_v,
                       input bit [NCH-1:0] sin, input bit rdy);
    rst = r;
    if_r.clear = clr;                if_l.clear = clr;
    if_r.global_counter = CNT_W'(gc); if_l.global_counter = CNT_W'(gc);
    if_r.en = en_v;                  if_l.en = en_v;
    if_r.serial_in = sin;            if_l.serial_in = sin;
    if_r.out_ready = rdy;            if_l.out_ready = rdy;
    model(r, clr, gc, en_v, sin, rdy);
  endtask

  task automatic step(input bit r, input bit clr, input int gc, input bit en_v,
                      input bit [NCH-1:0] sin, input bit rdy);
    @(negedge clk);
    drive(r, clr, gc, en_v, sin, rdy);
  endtask

  function automatic bit pick_rdy();
    return rand_rdy ? bit'($urandom_range(0, 1)) : rdy_base;
  endfunction

  // One free-running counter period; serial_in is noise except on the tick cycle.
  task automatic shift_bit(input bit [NCH-1:0] sin, input bit en_v, input bit rdy_tick);
    for (int gc = 0; gc < 32; gc++) begin
      if (gc == TICK) step(1'b0, 1'b0, gc, en_v, sin, rdy_tick);
      else            step(1'b0, 1'b0, gc, en_v, NCH'($urandom), pick_rdy());
    end
  endtask

  task automatic send_frame(input logic [NCH*WIDTH-1:0] f, input bit rdy_last);
    bit [NCH-1:0] sin;
    for (int i = 0; i < WIDTH; i++) begin
      for (int c = 0; c < NCH; c++) sin[c] = f[c*WIDTH + i];
      shift_bit(sin, 1'b1, (i == WIDTH - 1) ? rdy_last : rdy_base);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected record per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got 0 records expected 1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("r_bit_count",   if_r.bit_count,   e.bc);
        check("r_frame_valid", if_r.frame_valid, e.vld);
        check("r_overrun",     if_r.overrun,     e.ovr);
        check("r_frame_data",  if_r.frame_data,  e.fr);
        check("l_bit_count",   if_l.bit_count,   e.bc);
        check("l_frame_valid", if_l.frame_valid, e.vld);
        check("l_overrun",     if_l.overrun,     e.ovr);
        check("l_frame_data",  if_l.frame_data,  e.fl);
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, '0, 1'b0);
    settle();
    check("reset_frame_data", if_r.frame_data, 8'h00);
    check("reset_valid",      if_r.frame_valid, 1'b0);
    check("reset_overrun",    if_r.overrun, 1'b0);
    check("reset_bit_count",  if_r.bit_count, 0);

    send_frame(8'h8D, 1'b0);
    settle();
    check("right_frame_8D", if_r.frame_data, 8'h8D);
    check("left_frame_1B",  if_l.frame_data, 8'h1B);
    check("frame_valid_up", if_r.frame_valid, 1'b1);
    check("bit_count_wrap", if_r.bit_count, 0);

    for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 14, 1'b1, NCH'($urandom), 1'b0);
    for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 16, 1'b1, NCH'($urandom), 1'b0);
    shift_bit(2'b11, 1'b0, 1'b0);
    settle();
    check("gated_bit_count", if_r.bit_count, 0);

    send_frame(8'h00, 1'b0);
    settle();
    check("overrun_hold_data", if_r.frame_data, 8'h8D);
    check("overrun_hold_vld",  if_r.frame_valid, 1'b1);
    check("overrun_set",       if_r.overrun, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, NCH'($urandom), 1'b1);
    settle();
    check("pulse_valid_clr", if_r.frame_valid, 1'b0);
    check("pulse_ovr_stays", if_r.overrun, 1'b1);
    check("pulse_data_hold", if_r.frame_data, 8'h8D);

    step(1'b0, 1'b1, 0, 1'b1, NCH'($urandom), 1'b0);
    settle();
    check("clear_overrun", if_r.overrun, 1'b0);
    check("clear_data",    if_r.frame_data, 8'h00);

    send_frame(8'h3C, 1'b0);
    send_frame(8'h5A, 1'b1);
    settle();
    check("b2b_frame_5A", if_r.frame_data, 8'h5A);
    check("b2b_valid",    if_r.frame_valid, 1'b1);
    check("b2b_overrun",  if_r.overrun, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, '0, 1'b1);

    shift_bit(2'b01, 1'b1, 1'b0);
    shift_bit(2'b10, 1'b1, 1'b0);
    settle();
    check("mid_bit_count_2", if_r.bit_count, 2);
    step(1'b0, 1'b1, 0, 1'b1, NCH'($urandom), 1'b0);
    settle();
    check("mid_clear_bc",  if_r.bit_count, 0);
    check("mid_clear_vld", if_r.frame_valid, 1'b0);
    check("mid_clear_ovr", if_r.overrun, 1'b0);
    send_frame(8'h8D, 1'b0);
    settle();
    check("after_clear_8D", if_r.frame_data, 8'h8D);
    check("after_clear_1B", if_l.frame_data, 8'h1B);

    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 15) == 0) step(1'b0, 1'b1, 0, 1'b1, NCH'($urandom), pick_rdy());
      else shift_bit(NCH'($urandom), $urandom_range(0, 7) != 0, pick_rdy());
    end
    settle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
